// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI read-side controller:
//   - default parameter widths (ID, address, data)
//   - FSM state encoding for axi_read_ctrl
//   - AXI burst type and response code constants
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam int ID_W_DEF   = 8;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ADDR = 2'b01;
    localparam logic [1:0] ST_DATA = 2'b10;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_rd_cmd_reg.sv
// ---------------------------------------------------------------------------
// axi_rd_cmd_reg
// Command capture register for the AXI read controller. Latches the
// read command fields when 'load' is high and holds them until the next
// load or reset.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture strobe (command accepted this cycle)
//   id/addr/len/size/burst           incoming command fields
//   cmd_id/cmd_addr/cmd_len/cmd_size/cmd_burst   registered fields
// ---------------------------------------------------------------------------
module axi_rd_cmd_reg
    import axi_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ID_W-1:0]   id,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ID_W-1:0]   cmd_id,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    output logic [2:0]        cmd_size,
    output logic [1:0]        cmd_burst
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_id    <= '0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            cmd_size  <= '0;
            cmd_burst <= '0;
        end else if (load) begin
            cmd_id    <= id;
            cmd_addr  <= addr;
            cmd_len   <= len;
            cmd_size  <= size;
            cmd_burst <= burst;
        end
    end

endmodule

// File: rtl/axi_read_ctrl.sv
// ---------------------------------------------------------------------------
// axi_read_ctrl
// Single-outstanding AXI read controller. Accepts a read command from the
// load buffer, issues it on the AR channel, then forwards each accepted R
// beat to the load buffer one cycle later.
//
// Configuration macro:
//   AXI_RD_LEN_CHK_EN  defined   : burst ends when beat counter == len;
//                                  rd_err flags rlast/ID/response mismatches
//                      undefined : burst ends on the beat carrying rlast;
//                                  rd_err is tied low
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   load_axi_ar*               command from load buffer (valid/ready)
//   axi_ar*                    AXI read address channel
//   axi_r*                     AXI read data channel
//   ctrl_sram_rvld/rdata/rlast registered beat forwarded to load buffer
//   rd_busy                    controller not idle
//   rd_err                     sticky error, cleared on next command accept
//
// States:
//   state | meaning
//   IDLE  | waiting for a command, load_axi_arready high
//   ADDR  | presenting command on AR channel
//   DATA  | accepting R beats until the terminating beat
// ---------------------------------------------------------------------------
module axi_read_ctrl
    import axi_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_axi_arvalid,
    input  logic [ID_W-1:0]   load_axi_arid,
    input  logic [ADDR_W-1:0] load_axi_arraddr,
    input  logic [7:0]        load_axi_arlen,
    input  logic [2:0]        load_axi_arsize,
    input  logic [1:0]        load_axi_arburst,
    output logic              load_axi_arready,
    output logic              axi_arvalid,
    output logic [ID_W-1:0]   axi_arid,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic [7:0]        axi_arlen,
    output logic [2:0]        axi_arsize,
    output logic [1:0]        axi_arburst,
    input  logic              axi_arready,
    input  logic              axi_rvalid,
    input  logic [ID_W-1:0]   axi_rid,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast,
    output logic              axi_rready,
    output logic              ctrl_sram_rvld,
    output logic [DATA_W-1:0] ctrl_sram_rdata,
    output logic              ctrl_sram_rlast,
    output logic              rd_busy,
    output logic              rd_err
);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              cmd_accept;
    logic              beat;
    logic              beat_term;
    logic [7:0]        beat_cnt;
    logic [ID_W-1:0]   cmd_id;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic [2:0]        cmd_size;
    logic [1:0]        cmd_burst;

    assign load_axi_arready = (state == ST_IDLE);
    assign cmd_accept       = load_axi_arvalid & load_axi_arready;
    assign axi_arvalid      = (state == ST_ADDR);
    assign axi_rready       = (state == ST_DATA);
    assign beat             = axi_rvalid & axi_rready;
    assign rd_busy          = (state != ST_IDLE);

    assign axi_arid    = cmd_id;
    assign axi_araddr  = cmd_addr;
    assign axi_arlen   = cmd_len;
    assign axi_arsize  = cmd_size;
    assign axi_arburst = cmd_burst;

    axi_rd_cmd_reg #(
        .ID_W   (ID_W),
        .ADDR_W (ADDR_W)
    ) u_cmd_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cmd_accept),
        .id        (load_axi_arid),
        .addr      (load_axi_arraddr),
        .len       (load_axi_arlen),
        .size      (load_axi_arsize),
        .burst     (load_axi_arburst),
        .cmd_id    (cmd_id),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .cmd_burst (cmd_burst)
    );

`ifdef AXI_RD_LEN_CHK_EN
    // Equality compare only: len=255 ends on count 255, the wrap to 0 after
    // that beat is never observed.
    assign beat_term = (beat_cnt == cmd_len);
`else
    assign beat_term = axi_rlast;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (cmd_accept)       state_next = ST_ADDR;
            ST_ADDR: if (axi_arready)      state_next = ST_DATA;
            ST_DATA: if (beat & beat_term) state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (cmd_accept) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_sram_rvld  <= 1'b0;
            ctrl_sram_rlast <= 1'b0;
            ctrl_sram_rdata <= '0;
        end else begin
            ctrl_sram_rvld  <= beat;
            ctrl_sram_rlast <= beat & beat_term;
            if (beat) begin
                ctrl_sram_rdata <= axi_rdata;
            end
        end
    end

`ifdef AXI_RD_LEN_CHK_EN
    logic err_q;
    logic beat_bad;

    assign beat_bad = (axi_rlast != beat_term) | (axi_rid != cmd_id) |
                      (axi_rresp != RESP_OKAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (cmd_accept) begin
            err_q <= 1'b0;
        end else if (beat & beat_bad) begin
            err_q <= 1'b1;
        end
    end

    assign rd_err = err_q;
`else
    // ID and response are not checked in this build.
    logic unused_rsp;
    assign unused_rsp = ^{axi_rid, axi_rresp};
    assign rd_err     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_read_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_read_ctrl
// Self-checking bench for axi_read_ctrl. Drives inputs on the falling edge,
// checks outputs on the following falling edge against a transaction-level
// model of the expected forwarded beats, phase and error flag.
// Honours AXI_RD_LEN_CHK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_axi_read_ctrl;

`ifdef AXI_RD_LEN_CHK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        load_axi_arvalid;
    logic [7:0]  load_axi_arid;
    logic [11:0] load_axi_arraddr;
    logic [7:0]  load_axi_arlen;
    logic [2:0]  load_axi_arsize;
    logic [1:0]  load_axi_arburst;
    logic        load_axi_arready;
    logic        axi_arvalid;
    logic [7:0]  axi_arid;
    logic [11:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arready;
    logic        axi_rvalid;
    logic [7:0]  axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rready;
    logic        ctrl_sram_rvld;
    logic [31:0] ctrl_sram_rdata;
    logic        ctrl_sram_rlast;
    logic        rd_busy;
    logic        rd_err;

    axi_read_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_axi_arvalid (load_axi_arvalid),
        .load_axi_arid    (load_axi_arid),
        .load_axi_arraddr (load_axi_arraddr),
        .load_axi_arlen   (load_axi_arlen),
        .load_axi_arsize  (load_axi_arsize),
        .load_axi_arburst (load_axi_arburst),
        .load_axi_arready (load_axi_arready),
        .axi_arvalid      (axi_arvalid),
        .axi_arid         (axi_arid),
        .axi_araddr       (axi_araddr),
        .axi_arlen        (axi_arlen),
        .axi_arsize       (axi_arsize),
        .axi_arburst      (axi_arburst),
        .axi_arready      (axi_arready),
        .axi_rvalid       (axi_rvalid),
        .axi_rid          (axi_rid),
        .axi_rdata        (axi_rdata),
        .axi_rresp        (axi_rresp),
        .axi_rlast        (axi_rlast),
        .axi_rready       (axi_rready),
        .ctrl_sram_rvld   (ctrl_sram_rvld),
        .ctrl_sram_rdata  (ctrl_sram_rdata),
        .ctrl_sram_rlast  (ctrl_sram_rlast),
        .rd_busy          (rd_busy),
        .rd_err           (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected view after the next rising edge.
    int          phase;      // 0 idle, 1 address phase, 2 data phase
    logic        exp_rvld;
    logic [31:0] exp_data;
    logic        exp_last;
    logic        exp_err;
    logic [7:0]  cur_id;
    logic [11:0] cur_addr;
    logic [7:0]  cur_len;
    logic [2:0]  cur_size;
    logic [1:0]  cur_burst;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("rvld", 64'(ctrl_sram_rvld), 64'(exp_rvld));
        if (exp_rvld) begin
            check("rdata", 64'(ctrl_sram_rdata), 64'(exp_data));
            check("rlast", 64'(ctrl_sram_rlast), 64'(exp_last));
        end
        check("busy", 64'(rd_busy), 64'(phase != 0));
        check("load_arready", 64'(load_axi_arready), 64'(phase == 0));
        check("arvalid", 64'(axi_arvalid), 64'(phase == 1));
        check("rready", 64'(axi_rready), 64'(phase == 2));
        check("rd_err", 64'(rd_err), 64'(exp_err));
    endtask

    task automatic check_ar_fields(input string tag);
        check({tag, "_arid"},    64'(axi_arid),    64'(cur_id));
        check({tag, "_araddr"},  64'(axi_araddr),  64'(cur_addr));
        check({tag, "_arlen"},   64'(axi_arlen),   64'(cur_len));
        check({tag, "_arsize"},  64'(axi_arsize),  64'(cur_size));
        check({tag, "_arburst"}, 64'(axi_arburst), 64'(cur_burst));
    endtask

    // Issues one command and offers up to n_offer beats. The model decides
    // which beat ends the burst and whether the error flag must rise.
    task automatic run_burst(input logic [7:0] id, input logic [11:0] addr,
                             input logic [7:0] len, input int n_offer,
                             input int rlast_at, input int bad_id_at,
                             input int bad_resp_at, input int stall,
                             input bit fixed_first, input logic [31:0] first_data);
        int  n_stall;
        int  gap;
        int  i;
        bit  done;
        bit  term;
        logic [31:0] d;

        cur_id    = id;
        cur_addr  = addr;
        cur_len   = len;
        cur_size  = 3'($urandom_range(0, 7));
        cur_burst = 2'b01;

        load_axi_arvalid = 1'b1;
        load_axi_arid    = cur_id;
        load_axi_arraddr = cur_addr;
        load_axi_arlen   = cur_len;
        load_axi_arsize  = cur_size;
        load_axi_arburst = cur_burst;
        axi_rvalid       = 1'($urandom_range(0, 1));
        axi_rlast        = 1'($urandom_range(0, 1));
        phase    = 1;
        exp_rvld = 1'b0;
        exp_err  = 1'b0;
        tick();
        check_ar_fields("ar");

        n_stall = (stall < 0) ? $urandom_range(0, 4) : stall;
        for (int s = 0; s < n_stall; s++) begin
            // Garbage on the command and R inputs must not disturb the AR phase.
            load_axi_arvalid = 1'($urandom_range(0, 1));
            load_axi_arid    = 8'($urandom);
            load_axi_arraddr = 12'($urandom);
            load_axi_arlen   = 8'($urandom);
            axi_arready      = 1'b0;
            axi_rvalid       = 1'($urandom_range(0, 1));
            axi_rlast        = 1'($urandom_range(0, 1));
            axi_rdata        = $urandom;
            tick();
            check_ar_fields("ar_hold");
        end

        axi_arready = 1'b1;
        phase = 2;
        tick();
        axi_arready      = 1'b0;
        load_axi_arvalid = 1'b0;

        done = 1'b0;
        i = 0;
        while (!done && i < n_offer) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                axi_rvalid = 1'b0;
                axi_rlast  = 1'($urandom_range(0, 1));
                exp_rvld   = 1'b0;
                tick();
            end
            d = (fixed_first && i == 0) ? first_data : $urandom;
            axi_rvalid = 1'b1;
            axi_rdata  = d;
            axi_rid    = (i == bad_id_at) ? (id ^ 8'h01) : id;
            axi_rresp  = (i == bad_resp_at) ? 2'b10 : 2'b00;
            axi_rlast  = (i == rlast_at);

            term = LEN_CHK ? (i == int'(len)) : (i == rlast_at);
            if (LEN_CHK && ((i == rlast_at) != (i == int'(len)) ||
                            i == bad_id_at || i == bad_resp_at))
                exp_err = 1'b1;
            exp_rvld = 1'b1;
            exp_data = d;
            exp_last = term;
            if (term) begin
                phase = 0;
                done  = 1'b1;
            end
            tick();
            axi_rvalid = 1'b0;
            axi_rlast  = 1'b0;
            exp_rvld   = 1'b0;
            i++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n            = 1'b0;
        load_axi_arvalid = 1'b0;
        load_axi_arid    = '0;
        load_axi_arraddr = '0;
        load_axi_arlen   = '0;
        load_axi_arsize  = '0;
        load_axi_arburst = '0;
        axi_arready      = 1'b0;
        axi_rvalid       = 1'b0;
        axi_rid          = '0;
        axi_rdata        = '0;
        axi_rresp        = '0;
        axi_rlast        = 1'b0;
        phase    = 0;
        exp_rvld = 1'b0;
        exp_data = '0;
        exp_last = 1'b0;
        exp_err  = 1'b0;

        #3;
        check("rst_rvld",    64'(ctrl_sram_rvld), 64'd0);
        check("rst_arvalid", 64'(axi_arvalid),    64'd0);
        check("rst_araddr",  64'(axi_araddr),     64'd0);
        check("rst_busy",    64'(rd_busy),        64'd0);
        check("rst_err",     64'(rd_err),         64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single beat, fixed values.
        run_burst(8'h05, 12'h100, 8'd0, 1, 0, -1, -1, 0, 1'b1, 32'hDEADBEEF);
        tick();

        // Four-beat burst with gaps.
        run_burst(8'h21, 12'h240, 8'd3, 4, 3, -1, -1, -1, 1'b0, '0);

        // AR stall of five cycles.
        run_burst(8'h3c, 12'hA04, 8'd1, 2, 1, -1, -1, 5, 1'b0, '0);

        // Early rlast on the first of two beats.
        run_burst(8'h44, 12'h010, 8'd1, 2, 0, -1, -1, -1, 1'b0, '0);
        tick();
        // Next accept clears any error.
        run_burst(8'h45, 12'h020, 8'd0, 1, 0, -1, -1, -1, 1'b0, '0);

        // Error response on a single beat, data still forwarded.
        run_burst(8'h46, 12'h030, 8'd0, 1, 0, -1, 0, -1, 1'b0, '0);

        // Wrong ID in the middle of a burst.
        run_burst(8'h47, 12'h040, 8'd2, 3, 2, 1, -1, -1, 1'b0, '0);

        // Longest burst.
        run_burst(8'h99, 12'hFFC, 8'd255, 256, 255, -1, -1, 0, 1'b0, '0);

        // Randomized well-formed bursts.
        for (int k = 0; k < 10; k++) begin
            logic [7:0] l;
            l = 8'($urandom_range(0, 15));
            run_burst(8'($urandom), 12'($urandom), l, int'(l) + 1, int'(l),
                      -1, -1, -1, 1'b0, '0);
        end

        // Reset after two of four beats.
        run_burst(8'h77, 12'h700, 8'd3, 2, 3, -1, -1, -1, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_rvld",     64'(ctrl_sram_rvld),   64'd0);
        check("rstmid_rdata",    64'(ctrl_sram_rdata),  64'd0);
        check("rstmid_rlast",    64'(ctrl_sram_rlast),  64'd0);
        check("rstmid_arvalid",  64'(axi_arvalid),      64'd0);
        check("rstmid_araddr",   64'(axi_araddr),       64'd0);
        check("rstmid_arlen",    64'(axi_arlen),        64'd0);
        check("rstmid_rready",   64'(axi_rready),       64'd0);
        check("rstmid_busy",     64'(rd_busy),          64'd0);
        check("rstmid_err",      64'(rd_err),           64'd0);
        check("rstmid_arready",  64'(load_axi_arready), 64'd1);
        phase    = 0;
        exp_rvld = 1'b0;
        exp_err  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        axi_rvalid = 1'b1;
        axi_rdata  = 32'h1234_5678;
        tick();
        axi_rvalid = 1'b0;
        run_burst(8'h78, 12'h710, 8'd0, 1, 0, -1, -1, -1, 1'b1, 32'hCAFE_F00D);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
